// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory port between NUM_REQ requesters.
// A route FIFO steers in-order responses back to the port that issued each request.
module dmem_port_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ*32-1:0]  req_addr_i,
    input  logic [NUM_REQ-1:0]     req_write_i,
    input  logic [NUM_REQ*3-1:0]   req_size_i,
    input  logic [NUM_REQ*32-1:0]  req_data_i,
    input  logic [NUM_REQ*4-1:0]   req_strb_i,
    output logic [NUM_REQ-1:0]     rsp_valid_o,
    input  logic [NUM_REQ-1:0]     rsp_ready_i,
    output logic [31:0]            rsp_data_o,
    output logic                   rsp_error_o,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [31:0]            mem_req_addr_o,
    output logic                   mem_req_write_o,
    output logic [2:0]             mem_req_size_o,
    output logic [31:0]            mem_req_data_o,
    output logic [3:0]             mem_req_strb_o,
    input  logic                   mem_rsp_valid_i,
    output logic                   mem_rsp_ready_o,
    input  logic [31:0]            mem_rsp_data_i,
    input  logic                   mem_rsp_error_i,
    output logic                   unexpected_rsp_o
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [IDX_W-1:0] r_rr;
    logic             r_lock;
    logic [IDX_W-1:0] r_lock_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_unexp;

    logic [31:0]      w_addr  [NUM_REQ];
    logic             w_write [NUM_REQ];
    logic [2:0]       w_size  [NUM_REQ];
    logic [31:0]      w_data  [NUM_REQ];
    logic [3:0]       w_strb  [NUM_REQ];
    logic [IDX_W-1:0] w_grant;
    logic [IDX_W-1:0] w_rr_next;
    logic [IDX_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_req_hs;
    logic             w_rsp_hs;

    for (genvar n = 0; n < NUM_REQ; n++) begin : g_unpack
        assign w_addr[n]  = req_addr_i[32*n +: 32];
        assign w_write[n] = req_write_i[n];
        assign w_size[n]  = req_size_i[3*n +: 3];
        assign w_data[n]  = req_data_i[32*n +: 32];
        assign w_strb[n]  = req_strb_i[4*n +: 4];
    end

    assign w_full  = (r_cnt == CNT_W'(MAX_OUTSTANDING));
    assign w_empty = (r_cnt == '0);
    assign w_head  = r_fifo[r_rd_ptr];

    // Scan from r_rr upward with wrap; a held (locked) grant overrides the scan.
    always_comb begin : p_grant
        logic [IDX_W:0] scan;
        logic           found;
        w_grant = r_rr;
        found   = 1'b0;
        scan    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, r_rr} + (IDX_W+1)'(k);
            if (scan >= (IDX_W+1)'(NUM_REQ)) begin
                scan = scan - (IDX_W+1)'(NUM_REQ);
            end
            if (!found && req_valid_i[scan[IDX_W-1:0]]) begin
                w_grant = scan[IDX_W-1:0];
                found   = 1'b1;
            end
        end
        if (r_lock) begin
            w_grant = r_lock_idx;
        end
    end

    always_comb begin : p_rr_next
        logic [IDX_W:0] inc;
        inc       = {1'b0, w_grant} + (IDX_W+1)'(1);
        w_rr_next = (inc == (IDX_W+1)'(NUM_REQ)) ? '0 : inc[IDX_W-1:0];
    end

    assign mem_req_valid_o = req_valid_i[w_grant] & ~w_full;
    assign mem_req_addr_o  = w_addr[w_grant];
    assign mem_req_write_o = w_write[w_grant];
    assign mem_req_size_o  = w_size[w_grant];
    assign mem_req_data_o  = w_data[w_grant];
    assign mem_req_strb_o  = w_strb[w_grant];
    assign w_req_hs        = mem_req_valid_o & mem_req_ready_i;

    always_comb begin
        req_ready_o          = '0;
        req_ready_o[w_grant] = mem_req_ready_i & ~w_full;
    end

    // With nothing outstanding the response is swallowed so the wrapper never stalls.
    always_comb begin
        rsp_valid_o     = '0;
        mem_rsp_ready_o = 1'b1;
        if (!w_empty) begin
            rsp_valid_o[w_head] = mem_rsp_valid_i;
            mem_rsp_ready_o     = rsp_ready_i[w_head];
        end
    end

    assign w_rsp_hs         = mem_rsp_valid_i & mem_rsp_ready_o & ~w_empty;
    assign rsp_data_o       = mem_rsp_data_i;
    assign rsp_error_o      = mem_rsp_error_i;
    assign unexpected_rsp_o = r_unexp;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr       <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_cnt      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_unexp    <= 1'b0;
        end else begin
            r_unexp <= mem_rsp_valid_i & w_empty;
            if (w_req_hs) begin
                r_lock   <= 1'b0;
                r_rr     <= w_rr_next;
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end else if (mem_req_valid_o && !mem_req_ready_i) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_grant;
            end
            if (w_rsp_hs) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_req_hs, w_rsp_hs})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Route entries are only read while valid, so the storage needs no reset.
    always_ff @(posedge clk_i) begin
        if (w_req_hs) begin
            r_fifo[r_wr_ptr] <= w_grant;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a randomized run
// compared against a queue-based reference model of arbitration and response routing.
module tb_dmem_port_arbiter;
    localparam int MAXO = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  req_valid_i, req_ready_o, req_write_i, rsp_valid_o, rsp_ready_i;
    logic [63:0] req_addr_i, req_data_i;
    logic [5:0]  req_size_i;
    logic [7:0]  req_strb_i;
    logic [31:0] rsp_data_o, mem_req_addr_o, mem_req_data_o, mem_rsp_data_i;
    logic        rsp_error_o, mem_req_valid_o, mem_req_ready_i, mem_req_write_o;
    logic [2:0]  mem_req_size_o;
    logic [3:0]  mem_req_strb_o;
    logic        mem_rsp_valid_i, mem_rsp_ready_o, mem_rsp_error_i, unexpected_rsp_o;

    logic [31:0] b_addr [2];
    logic        b_write [2];
    logic [2:0]  b_size [2];
    logic [31:0] b_data [2];
    logic [3:0]  b_strb [2];

    assign req_addr_i  = {b_addr[1], b_addr[0]};
    assign req_write_i = {b_write[1], b_write[0]};
    assign req_size_i  = {b_size[1], b_size[0]};
    assign req_data_i  = {b_data[1], b_data[0]};
    assign req_strb_i  = {b_strb[1], b_strb[0]};

    dmem_port_arbiter #(.NUM_REQ(2), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_write_i(req_write_i), .req_size_i(req_size_i), .req_data_i(req_data_i),
        .req_strb_i(req_strb_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_error_o(rsp_error_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_write_o(mem_req_write_o),
        .mem_req_size_o(mem_req_size_o), .mem_req_data_o(mem_req_data_o),
        .mem_req_strb_o(mem_req_strb_o), .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_ready_o(mem_rsp_ready_o), .mem_rsp_data_i(mem_rsp_data_i),
        .mem_rsp_error_i(mem_rsp_error_i), .unexpected_rsp_o(unexpected_rsp_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: round-robin pointer, hold-while-stalled, and an in-order route queue.
    bit   m_rr, m_lock, m_lock_idx;
    bit   m_q[$];
    logic m_unexp;
    bit   e_grant;
    logic e_full, e_mvalid, e_req_hs, e_mrsp_ready, e_rsp_hs, e_unexp_d;
    logic [1:0] e_rdy, e_rsp_valid;

    function automatic void model_reset();
        m_rr = 1'b0; m_lock = 1'b0; m_lock_idx = 1'b0; m_unexp = 1'b0;
        m_q.delete();
    endfunction

    function automatic void model_eval();
        bit g;
        e_full = (m_q.size() >= MAXO);
        if (m_lock)                g = m_lock_idx;
        else if (req_valid_i[m_rr])  g = m_rr;
        else if (req_valid_i[~m_rr]) g = ~m_rr;
        else                       g = m_rr;
        e_grant  = g;
        e_mvalid = req_valid_i[g] && !e_full;
        e_rdy    = 2'b00;
        if (mem_req_ready_i && !e_full) e_rdy[g] = 1'b1;
        e_req_hs    = e_mvalid && mem_req_ready_i;
        e_rsp_valid = 2'b00;
        e_mrsp_ready = 1'b1;
        if (m_q.size() != 0) begin
            e_rsp_valid[m_q[0]] = mem_rsp_valid_i;
            e_mrsp_ready        = rsp_ready_i[m_q[0]];
        end
        e_rsp_hs  = mem_rsp_valid_i && e_mrsp_ready && (m_q.size() != 0);
        e_unexp_d = mem_rsp_valid_i && (m_q.size() == 0);
    endfunction

    function automatic void model_commit();
        if (e_rsp_hs) void'(m_q.pop_front());
        if (e_req_hs) begin
            m_q.push_back(e_grant);
            m_rr   = ~e_grant;
            m_lock = 1'b0;
        end else if (e_mvalid && !mem_req_ready_i) begin
            m_lock     = 1'b1;
            m_lock_idx = e_grant;
        end
        m_unexp = e_unexp_d;
    endfunction

    task automatic settle();
        @(negedge clk_i);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk_i);
        model_commit();
        #1;
    endtask

    task automatic clear_inputs();
        req_valid_i = 2'b00; rsp_ready_i = 2'b11;
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i = 32'h0; mem_rsp_error_i = 1'b0;
        for (int p = 0; p < 2; p++) begin
            b_addr[p] = 32'h0; b_write[p] = 1'b0; b_size[p] = 3'd2;
            b_data[p] = 32'h0; b_strb[p] = 4'hF;
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_inputs();
        model_reset();
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic drain();
        req_valid_i = 2'b00; mem_rsp_valid_i = 1'b1; rsp_ready_i = 2'b11;
        for (int i = 0; i < 8 && m_q.size() != 0; i++) begin
            settle();
            advance();
        end
        mem_rsp_valid_i = 1'b0;
        n_checks++;
        if (m_q.size() != 0) begin n_fail++; $display("FAIL drain_bound outstanding=%0d required=0", m_q.size()); end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        clear_inputs();
        model_reset();
        @(negedge clk_i);
        n_checks++;
        if ({mem_req_valid_o, req_ready_o} !== 3'b000) begin n_fail++; $display("FAIL reset_req got=%b exp=000", {mem_req_valid_o, req_ready_o}); end
        n_checks++;
        if ({mem_rsp_ready_o, rsp_valid_o, unexpected_rsp_o} !== 4'b1000) begin n_fail++; $display("FAIL reset_rsp got=%b exp=1000", {mem_rsp_ready_o, rsp_valid_o, unexpected_rsp_o}); end
        @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req_valid_i = 2'b01; b_addr[0] = 32'h0000_0100; b_size[0] = 3'd2; mem_req_ready_i = 1'b1;
        settle();
        n_checks++;
        if ({mem_req_valid_o, req_ready_o} !== 3'b101) begin n_fail++; $display("FAIL single_req got=%b exp=101", {mem_req_valid_o, req_ready_o}); end
        n_checks++;
        if ({mem_req_addr_o, mem_req_size_o} !== {32'h0000_0100, 3'd2}) begin n_fail++; $display("FAIL single_payload got=%h/%0d exp=00000100/2", mem_req_addr_o, mem_req_size_o); end
        advance();
        req_valid_i = 2'b00;
        settle(); advance();
        mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'hDEAD_BEEF;
        settle();
        n_checks++;
        if ({rsp_valid_o, rsp_data_o} !== {2'b01, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL single_rsp got=%b/%h exp=01/deadbeef", rsp_valid_o, rsp_data_o); end
        advance();
        settle();
        n_checks++;
        if ({rsp_valid_o, mem_rsp_ready_o} !== 3'b001) begin n_fail++; $display("FAIL single_empty got=%b exp=001", {rsp_valid_o, mem_rsp_ready_o}); end
        advance();
        mem_rsp_valid_i = 1'b0;
        settle();
        n_checks++;
        if (unexpected_rsp_o !== 1'b1) begin n_fail++; $display("FAIL single_cnt0 unexpected=%b exp=1", unexpected_rsp_o); end
        advance();
    endtask

    task automatic test_alternate();
        logic [1:0] exp_rdy, exp_rsp;
        do_reset();
        req_valid_i = 2'b11; b_addr[0] = 32'h10; b_addr[1] = 32'h20; mem_req_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) req_valid_i = 2'b00;
            mem_rsp_valid_i = (k > 0);
            exp_rdy = (k == 4) ? 2'b01 : ((k % 2 == 1) ? 2'b10 : 2'b01);
            exp_rsp = (k == 0) ? 2'b00 : (((k - 1) % 2 == 1) ? 2'b10 : 2'b01);
            settle();
            n_checks++;
            if (k < 4 && req_ready_o !== exp_rdy) begin n_fail++; $display("FAIL alt_grant%0d got=%b exp=%b", k, req_ready_o, exp_rdy); end
            n_checks++;
            if (rsp_valid_o !== exp_rsp) begin n_fail++; $display("FAIL alt_route%0d got=%b exp=%b", k, rsp_valid_o, exp_rsp); end
            advance();
        end
        mem_rsp_valid_i = 1'b0;
    endtask

    task automatic test_lock();
        do_reset();
        req_valid_i = 2'b10; b_addr[1] = 32'h200; b_addr[0] = 32'h400;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) req_valid_i = 2'b11;
            settle();
            n_checks++;
            if ({mem_req_valid_o, req_ready_o, mem_req_addr_o} !== {3'b100, 32'h200}) begin n_fail++; $display("FAIL lock_hold%0d got=%b/%h exp=100/200", c, {mem_req_valid_o, req_ready_o}, mem_req_addr_o); end
            advance();
        end
        mem_req_ready_i = 1'b1;
        settle();
        n_checks++;
        if ({req_ready_o, mem_req_addr_o} !== {2'b10, 32'h200}) begin n_fail++; $display("FAIL lock_hs got=%b/%h exp=10/200", req_ready_o, mem_req_addr_o); end
        advance();
        req_valid_i = 2'b01;
        settle();
        n_checks++;
        if ({req_ready_o, mem_req_addr_o} !== {2'b01, 32'h400}) begin n_fail++; $display("FAIL lock_next got=%b/%h exp=01/400", req_ready_o, mem_req_addr_o); end
        advance();
        drain();
    endtask

    task automatic test_full();
        do_reset();
        req_valid_i = 2'b01; b_addr[0] = 32'h300; mem_req_ready_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            settle();
            n_checks++;
            if ({mem_req_valid_o, req_ready_o} !== 3'b101) begin n_fail++; $display("FAIL full_acc%0d got=%b exp=101", c, {mem_req_valid_o, req_ready_o}); end
            advance();
        end
        settle();
        n_checks++;
        if ({mem_req_valid_o, req_ready_o} !== 3'b000) begin n_fail++; $display("FAIL full_block got=%b exp=000", {mem_req_valid_o, req_ready_o}); end
        advance();
        mem_rsp_valid_i = 1'b1;
        settle();
        n_checks++;
        if ({mem_req_valid_o, rsp_valid_o} !== 3'b001) begin n_fail++; $display("FAIL full_nobypass got=%b exp=001", {mem_req_valid_o, rsp_valid_o}); end
        advance();
        mem_rsp_valid_i = 1'b0;
        settle();
        n_checks++;
        if ({mem_req_valid_o, req_ready_o} !== 3'b101) begin n_fail++; $display("FAIL full_third got=%b exp=101", {mem_req_valid_o, req_ready_o}); end
        advance();
        drain();
    endtask

    task automatic test_unexpected();
        do_reset();
        mem_rsp_valid_i = 1'b1; rsp_ready_i = 2'b00;
        settle();
        n_checks++;
        if ({mem_rsp_ready_o, rsp_valid_o, unexpected_rsp_o} !== 4'b1000) begin n_fail++; $display("FAIL unexp_accept got=%b exp=1000", {mem_rsp_ready_o, rsp_valid_o, unexpected_rsp_o}); end
        advance();
        mem_rsp_valid_i = 1'b0;
        settle();
        n_checks++;
        if (unexpected_rsp_o !== 1'b1) begin n_fail++; $display("FAIL unexp_pulse got=%b exp=1", unexpected_rsp_o); end
        advance();
        settle();
        n_checks++;
        if (unexpected_rsp_o !== 1'b0) begin n_fail++; $display("FAIL unexp_single got=%b exp=0", unexpected_rsp_o); end
        advance();
    endtask

    task automatic test_error_hold();
        do_reset();
        req_valid_i = 2'b01; mem_req_ready_i = 1'b1;
        settle(); advance();
        req_valid_i = 2'b00;
        mem_rsp_valid_i = 1'b1; mem_rsp_error_i = 1'b1; rsp_ready_i = 2'b00;
        for (int c = 0; c < 2; c++) begin
            settle();
            n_checks++;
            if ({mem_rsp_ready_o, rsp_valid_o} !== 3'b001) begin n_fail++; $display("FAIL err_hold%0d got=%b exp=001", c, {mem_rsp_ready_o, rsp_valid_o}); end
            advance();
        end
        rsp_ready_i = 2'b01;
        settle();
        n_checks++;
        if ({mem_rsp_ready_o, rsp_valid_o, rsp_error_o} !== 4'b1011) begin n_fail++; $display("FAIL err_release got=%b exp=1011", {mem_rsp_ready_o, rsp_valid_o, rsp_error_o}); end
        advance();
        settle();
        n_checks++;
        if (rsp_valid_o !== 2'b00) begin n_fail++; $display("FAIL err_single_pop got=%b exp=00", rsp_valid_o); end
        advance();
        mem_rsp_valid_i = 1'b0; mem_rsp_error_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid_i = 2'b10; mem_req_ready_i = 1'b1; rsp_ready_i = 2'b00;
        settle(); advance();
        req_valid_i = 2'b00;
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (mem_rsp_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_async got=%b exp=1", mem_rsp_ready_o); end
        do_reset();
        rsp_ready_i = 2'b00; mem_rsp_valid_i = 1'b1;
        settle();
        n_checks++;
        if ({rsp_valid_o, mem_rsp_ready_o} !== 3'b001) begin n_fail++; $display("FAIL rstmid_drop got=%b exp=001", {rsp_valid_o, mem_rsp_ready_o}); end
        advance();
        mem_rsp_valid_i = 1'b0;
        settle();
        n_checks++;
        if (unexpected_rsp_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_flag got=%b exp=1", unexpected_rsp_o); end
        advance();
    endtask

    task automatic test_random();
        bit hold [2];
        do_reset();
        hold[0] = 1'b0; hold[1] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!hold[p]) begin
                    req_valid_i[1'(p)] = ($urandom_range(0, 2) != 0);
                    b_addr[p] = $urandom; b_write[p] = $urandom_range(0, 1) != 0;
                    b_size[p] = 3'($urandom_range(0, 2)); b_data[p] = $urandom;
                    b_strb[p] = 4'($urandom_range(0, 15));
                end
            end
            mem_req_ready_i = ($urandom_range(0, 3) != 0);
            mem_rsp_valid_i = ($urandom_range(0, 2) == 0);
            rsp_ready_i     = 2'($urandom_range(0, 3));
            mem_rsp_data_i  = $urandom;
            mem_rsp_error_i = ($urandom_range(0, 7) == 0);
            settle();
            n_checks++;
            if ({mem_req_valid_o, req_ready_o} !== {e_mvalid, e_rdy}) begin n_fail++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, {mem_req_valid_o, req_ready_o}, {e_mvalid, e_rdy}); end
            if (e_mvalid) begin
                n_checks++;
                if ({mem_req_addr_o, mem_req_write_o, mem_req_size_o, mem_req_data_o, mem_req_strb_o} !==
                    {b_addr[e_grant], b_write[e_grant], b_size[e_grant], b_data[e_grant], b_strb[e_grant]}) begin
                    n_fail++; $display("FAIL rnd_payload c=%0d got=%h exp=%h", c, mem_req_addr_o, b_addr[e_grant]);
                end
            end
            n_checks++;
            if ({rsp_valid_o, mem_rsp_ready_o} !== {e_rsp_valid, e_mrsp_ready}) begin n_fail++; $display("FAIL rnd_rsp c=%0d got=%b exp=%b", c, {rsp_valid_o, mem_rsp_ready_o}, {e_rsp_valid, e_mrsp_ready}); end
            n_checks++;
            if ({rsp_data_o, rsp_error_o, unexpected_rsp_o} !== {mem_rsp_data_i, mem_rsp_error_i, m_unexp}) begin n_fail++; $display("FAIL rnd_pass c=%0d got=%h/%b/%b exp=%h/%b/%b", c, rsp_data_o, rsp_error_o, unexpected_rsp_o, mem_rsp_data_i, mem_rsp_error_i, m_unexp); end
            for (int p = 0; p < 2; p++) begin
                hold[p] = req_valid_i[1'(p)] && !(e_req_hs && (e_grant == 1'(p)));
            end
            advance();
        end
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_lock();
        test_full();
        test_unexpected();
        test_error_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares the single memory-wrapper data interface (valid/ready request, valid/ready response) between NUM_REQ requesters. Port 0 is the core MEM stage; port 1 is the debug/DMA master. It arbitrates requests round-robin, holds a grant while the downstream side backpressures, and tracks outstanding transactions. Responses are routed back to the originating port in request order.

Parameters:
NUM_REQ, 2, number of requesters (≥2).
MAX_OUTSTANDING, 2, max accepted-but-unanswered transactions (≥1); also the depth of the route FIFO.

Ports:
clk_i  input  1  clock
rst_i  input  1  reset; one clock; reset is asynchronous and active-high
req_valid_i  input  NUM_REQ  per-port request valid
req_ready_o  output  NUM_REQ  per-port request accepted
req_addr_i  input  NUM_REQ*32  per-port byte address (port n at [32n+:32])
req_write_i  input  NUM_REQ  per-port write flag
req_size_i  input  NUM_REQ*3  per-port size (0=byte, 1=half, 2=word)
req_data_i  input  NUM_REQ*32  per-port write data, lane-aligned
req_strb_i  input  NUM_REQ*4  per-port write strobes
rsp_valid_o  output  NUM_REQ  per-port response valid
rsp_ready_i  input  NUM_REQ  per-port response ready
rsp_data_o  output  32  response data, broadcast to all ports
rsp_error_o  output  1  response error, broadcast to all ports
mem_req_valid_o  output  1  downstream request valid
mem_req_ready_i  input  1  downstream request ready
mem_req_addr_o  output  32  muxed address
mem_req_write_o  output  1  muxed write flag
mem_req_size_o  output  3  muxed size
mem_req_data_o  output  32  muxed write data
mem_req_strb_o  output  4  muxed strobes
mem_rsp_valid_i  input  1  downstream response valid
mem_rsp_ready_o  output  1  downstream response ready
mem_rsp_data_i  input  32  downstream response data
mem_rsp_error_i  input  1  downstream response error
unexpected_rsp_o  output  1  one-cycle pulse: response arrived with nothing outstanding

Behaviour:
- State: round-robin pointer rr_q; lock flag plus locked index; outstanding count cnt_q, width $clog2(MAX_OUTSTANDING+1); route FIFO holding granted indices.
- Reset: rr_q=0, lock clear, cnt_q=0, FIFO empty, unexpected_rsp_o=0. Combinational outputs follow from this state: mem_req_valid_o=0 and req_ready_o=0 unless inputs are active; mem_rsp_ready_o=1.
- full = (cnt_q == MAX_OUTSTANDING). The full check does not bypass a response retiring in the same cycle.
- Grant selection:
  - If lock is set, grant = locked index.
  - Otherwise grant = the first valid port scanning rr_q, rr_q+1, … mod NUM_REQ.
  - With no valid port, grant = rr_q and the payload is don't-care.
- Request path: zero latency, purely combinational.
  - mem_req_valid_o = req_valid_i[grant] & ~full.
  - mem_req_* payload = payload of the granted port.
  - req_ready_o[grant] = mem_req_ready_i & ~full; all other bits are 0.
- Lock: set when mem_req_valid_o & ~mem_req_ready_i; cleared on handshake. Requesters must hold valid and payload stable until ready. The arbiter never switches grant while locked.
- On a request handshake:
  - push grant into the FIFO, cnt_q++;
  - rr_q = (grant+1) mod NUM_REQ.
- Response path (memory wrapper returns responses in request order):
  - FIFO non-empty: rsp_valid_o[head] = mem_rsp_valid_i, other bits 0; mem_rsp_ready_o = rsp_ready_i[head].
  - On response handshake: pop FIFO, cnt_q--.
  - rsp_data_o/rsp_error_o pass through unregistered.
- Simultaneous request and response handshake: push and pop both occur, cnt_q is unchanged. The FIFO wraps at depth MAX_OUTSTANDING.
- Response with FIFO empty:
  - mem_rsp_ready_o=1, the response is discarded and rsp_valid_o=0;
  - unexpected_rsp_o is registered high for exactly the next cycle.
- Reset mid-transaction drops all outstanding routing. Late responses are discarded and flagged as unexpected.
- Errors are only forwarded. Exception generation belongs to the requester.
- cnt_q never exceeds MAX_OUTSTANDING and never underflows.

Test Plan:
1. Port0 LW to 0x0000_0100, mem_req_ready_i=1 → mem_req_valid_o and req_ready_o=01 in the same cycle, mem_req_size_o=2. A response of 0xDEADBEEF two cycles later → rsp_valid_o=01, rsp_data_o=0xDEADBEEF, cnt_q returns to 0.
2. Both ports valid continuously, ready=1, each response returned one cycle after its request → grants alternate 0,1,0,1 and responses route 0,1,0,1.
3. Port1 valid at 0x200 with mem_req_ready_i=0 for 3 cycles; port0 raises valid in cycle 2 → payload stays 0x200 and the grant stays 1 until the handshake; port0 is granted in the following cycle.
4. MAX_OUTSTANDING=2, no responses, 3 requests → two handshakes, then mem_req_valid_o=0 and req_ready_o=00. One response → the third request is accepted in the next cycle, not in the response cycle.
5. mem_rsp_valid_i=1 with nothing outstanding → mem_rsp_ready_o=1, rsp_valid_o=00, unexpected_rsp_o=1 for exactly one cycle afterwards.
6. Head=port0 with rsp_ready_i[0]=0 for 2 cycles and mem_rsp_error_i=1 → mem_rsp_ready_o=0 and the FIFO holds. Releasing ready → rsp_error_o=1 to port0 and a single pop.
